// File: rtl/window_fetch.sv
// 3x3 sliding-window fetcher: scans the interior of a 64x64 frame and emits one window per centre pixel.
// Optional WINDOW_REUSE_EN: keep the two previous columns and fetch only the new right-hand column.
module window_fetch (
   input  logic                  Clock,
   input  logic                  Resetn,
   input  logic                  Start,
   input  logic                  WriteEn,
   output logic                  MEM_rd,
   output logic [5:0]            MEM_row,
   output logic [5:0]            MEM_col,
   input  logic [7:0]            MEM_data,
   output logic                  F_Enable,
   output logic                  F_MemWrite,
   output logic [5:0]            F_row,
   output logic [5:0]            F_col,
   output logic [2:0][2:0][7:0]  WOUT,
   output logic                  Busy,
   output logic                  Done
);

`ifdef WINDOW_REUSE_EN
   localparam bit REUSE = 1'b1;
`else
   localparam bit REUSE = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, FIN} state_t;

   state_t     state, state_next;
   logic [1:0] rd_i, rd_j;
   logic [1:0] pend_i, pend_j;
   logic       pend_vld;
   logic       last_rd, last_win, row_end, partial;

   // A partial load only reads column 2; since rd_j then sits at 2, one test covers both load types.
   assign last_rd  = (rd_i == 2'd2) && (rd_j == 2'd2);
   assign last_win = (F_row == 6'd62) && (F_col == 6'd62);
   assign row_end  = (F_col == 6'd62);
   assign partial  = REUSE && (F_col != 6'd1);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (Start) state_next = FETCH;
         FETCH:   if (last_rd) state_next = WAIT;
         WAIT:    state_next = EMIT;
         EMIT:    state_next = last_win ? FIN : FETCH;
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      MEM_rd   = (state == FETCH);
      MEM_row  = 6'd0;
      MEM_col  = 6'd0;
      if (MEM_rd) begin
         MEM_row = F_row + {4'd0, rd_i} - 6'd1;
         MEM_col = F_col + {4'd0, rd_j} - 6'd1;
      end
      F_Enable = (state == EMIT);
      Busy     = (state == FETCH) || (state == WAIT) || (state == EMIT);
      Done     = (state == FIN);
   end

   // Read data arrives one cycle late, so the slot of each read is carried alongside a valid flag.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         F_row      <= 6'd0;
         F_col      <= 6'd0;
         F_MemWrite <= 1'b0;
         rd_i       <= 2'd0;
         rd_j       <= 2'd0;
         pend_vld   <= 1'b0;
         pend_i     <= 2'd0;
         pend_j     <= 2'd0;
         WOUT       <= '0;
      end else begin
         pend_vld <= (state == FETCH);
         pend_i   <= rd_i;
         pend_j   <= rd_j;
         case (state)
            IDLE: begin
               if (Start) begin
                  F_row      <= 6'd1;
                  F_col      <= 6'd1;
                  F_MemWrite <= WriteEn;
                  rd_i       <= 2'd0;
                  rd_j       <= 2'd0;
               end
            end
            FETCH: begin
               if (rd_j == 2'd2) begin
                  rd_i <= rd_i + 2'd1;
                  rd_j <= partial ? 2'd2 : 2'd0;
               end else begin
                  rd_j <= rd_j + 2'd1;
               end
            end
            EMIT: begin
               if (!last_win) begin
                  rd_i <= 2'd0;
                  if (row_end) begin
                     F_row <= F_row + 6'd1;
                     F_col <= 6'd1;
                     rd_j  <= 2'd0;
                  end else begin
                     F_col <= F_col + 6'd1;
                     rd_j  <= REUSE ? 2'd2 : 2'd0;
                     if (REUSE) begin
                        for (int i = 0; i < 3; i++) begin
                           WOUT[i][0] <= WOUT[i][1];
                           WOUT[i][1] <= WOUT[i][2];
                        end
                     end
                  end
               end
            end
            default: ;
         endcase
         if (pend_vld) WOUT[pend_i][pend_j] <= MEM_data;
      end
   end

endmodule

// File: tb/tb_window_fetch.sv
// Directed bench for window_fetch: image pixel(r,c)=(r+c) mod 256, abort-by-reset, full scan with Start-while-busy.
module tb_window_fetch;

`ifdef WINDOW_REUSE_EN
   localparam bit REUSE = 1'b1;
`else
   localparam bit REUSE = 1'b0;
`endif

   logic                 Clock = 1'b0;
   logic                 Resetn, Start, WriteEn;
   logic                 MEM_rd;
   logic [5:0]           MEM_row, MEM_col;
   logic [7:0]           MEM_data = 8'h00;
   logic                 F_Enable, F_MemWrite, Busy, Done;
   logic [5:0]           F_row, F_col;
   logic [2:0][2:0][7:0] WOUT;

   int checks = 0;
   int errors = 0;
   int expR, expC, winCount, doneCount;
   int sinceLast = 0, rdCount = 0, busyCycles = 0;
   bit prevBusy = 1'b0;
   bit scanWe;
   logic [7:0] lastW22 = 8'h00;

   window_fetch dut (
      .Clock(Clock), .Resetn(Resetn), .Start(Start), .WriteEn(WriteEn),
      .MEM_rd(MEM_rd), .MEM_row(MEM_row), .MEM_col(MEM_col), .MEM_data(MEM_data),
      .F_Enable(F_Enable), .F_MemWrite(F_MemWrite), .F_row(F_row), .F_col(F_col),
      .WOUT(WOUT), .Busy(Busy), .Done(Done)
   );

   always #5 Clock = ~Clock;

   // Image memory with one-cycle read latency; idle cycles return a marker value.
   always @(posedge Clock)
      MEM_data <= MEM_rd ? 8'({2'b00, MEM_row} + {2'b00, MEM_col}) : 8'hA5;

   task automatic checkOutput(input string tag, input logic [71:0] actual, input logic [71:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   function automatic logic [71:0] expWin(input int r, input int c);
      logic [2:0][2:0][7:0] w;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[i][j] = 8'(r - 1 + i + c - 1 + j);
      return w;
   endfunction

   task automatic checkZero(input string tag);
      checkOutput({tag, "_ctrl"}, 72'({F_Enable, F_MemWrite, MEM_rd, Busy, Done}), 72'd0);
      checkOutput({tag, "_coord"}, 72'({F_row, F_col, MEM_row, MEM_col}), 72'd0);
      checkOutput({tag, "_wout"}, WOUT, 72'd0);
   endtask

   // Reference model of the window sequence, read counts and window period.
   always @(negedge Clock) begin
      if (Resetn) begin
         if (Busy && !prevBusy) begin
            sinceLast  = 0;
            rdCount    = 0;
            busyCycles = 0;
         end
         prevBusy = Busy;
         sinceLast++;
         if (MEM_rd) rdCount++;
         if (Busy) busyCycles++;
         if (F_Enable) begin
            int n;
            n = (REUSE && expC != 1) ? 3 : 9;
            checkOutput("win_row", 72'(F_row), 72'(expR));
            checkOutput("win_col", 72'(F_col), 72'(expC));
            checkOutput("win_data", WOUT, expWin(expR, expC));
            checkOutput("win_memwrite", 72'(F_MemWrite), 72'(scanWe));
            checkOutput("win_reads", 72'(rdCount), 72'(n));
            checkOutput("win_period", 72'(sinceLast), 72'(n + 2));
            lastW22   = WOUT[2][2];
            sinceLast = 0;
            rdCount   = 0;
            winCount++;
            if (expC == 62) begin
               expC = 1;
               expR++;
            end else begin
               expC++;
            end
         end
         if (Done) begin
            doneCount++;
            checkOutput("done_wins", 72'(winCount), 72'd3844);
            checkOutput("done_busy", 72'(Busy), 72'd0);
            checkOutput("done_cycles", 72'(busyCycles), REUSE ? 72'd19592 : 72'd42284);
         end
      end else begin
         prevBusy = 1'b0;
      end
   end

   task automatic applyStimulus(input bit we);
      @(negedge Clock);
      scanWe   = we;
      WriteEn  = we;
      expR     = 1;
      expC     = 1;
      winCount = 0;
      doneCount = 0;
      Start    = 1'b1;
      @(negedge Clock);
      Start    = 1'b0;
      WriteEn  = ~we;
   endtask

   task automatic waitWindows(input int target, input int budget);
      int k;
      k = 0;
      while (winCount < target && k < budget) begin
         @(posedge Clock);
         k++;
      end
      if (winCount < target) checkOutput("timeout_windows", 72'(winCount), 72'(target));
   endtask

   initial begin
      int n;
      Resetn  = 1'b0;
      Start   = 1'b0;
      WriteEn = 1'b0;
      scanWe  = 1'b0;
      expR = 1; expC = 1; winCount = 0; doneCount = 0;
      repeat (3) @(negedge Clock);
      checkZero("reset");
      Resetn = 1'b1;

      // Scan aborted by reset while fetching window (1,3).
      applyStimulus(1'b1);
      waitWindows(2, 200);
      n = 0;
      for (int k = 0; k < 50 && n < (REUSE ? 2 : 5); k++) begin
         @(negedge Clock);
         if (MEM_rd) n++;
      end
      checkOutput("abort_fetch_cycle", 72'(n), REUSE ? 72'd2 : 72'd5);
      Resetn = 1'b0;
      #1 checkZero("abort_async");
      @(negedge Clock);
      checkZero("abort_hold");
      repeat (2) @(negedge Clock);
      Resetn = 1'b1;
      repeat (3) begin
         @(negedge Clock);
         checkOutput("idle_no_enable", 72'({F_Enable, Busy, MEM_rd}), 72'd0);
      end
      checkOutput("abort_windows", 72'(winCount), 72'd2);

      // Full scan with WriteEn low at Start, then raised, plus a Start pulse while busy.
      applyStimulus(1'b0);
      waitWindows(100, 5000);
      @(negedge Clock);
      WriteEn = 1'b1;
      Start   = 1'b1;
      @(negedge Clock);
      Start   = 1'b0;
      n = 0;
      while (doneCount < 1 && n < 50000) begin
         @(posedge Clock);
         n++;
      end
      checkOutput("scan_done_seen", 72'(doneCount), 72'd1);
      @(negedge Clock);
      checkOutput("end_busy", 72'({Busy, Done, F_Enable}), 72'd0);
      checkOutput("end_windows", 72'(winCount), 72'd3844);
      checkOutput("end_last_w22", 72'(lastW22), 72'd126);
      checkOutput("end_coord", 72'({F_row, F_col}), 72'({6'd62, 6'd62}));
      repeat (5) @(negedge Clock);
      checkOutput("end_single_done", 72'(doneCount), 72'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
